// File: rtl/monster_pkg.sv
// Shared types and screen geometry for the monster controller.
package monster_pkg;

    typedef enum logic [1:0] {
        ST_CHASE  = 2'd0,
        ST_FRIGHT = 2'd1,
        ST_DEAD   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int OBJ_SIZE = 32;

    // Largest legal top-left coordinate keeps the 32x32 sprite on screen.
    localparam logic [10:0] X_MAX = 11'(SCREEN_W - OBJ_SIZE - 1);
    localparam logic [10:0] Y_MAX = 11'(SCREEN_H - OBJ_SIZE - 1);

    // Bit positions inside HitEdgeCode = {Left,Top,Right,Bottom}.
    localparam int EDGE_LEFT   = 3;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_BOTTOM = 0;

    function automatic dir_t dir_flip(input dir_t d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

    // True when the wall edge in front of the current heading was touched.
    function automatic logic faces_wall(input dir_t d, input logic [3:0] f);
        case (d)
            DIR_LEFT:  return f[EDGE_LEFT];
            DIR_UP:    return f[EDGE_TOP];
            DIR_RIGHT: return f[EDGE_RIGHT];
            default:   return f[EDGE_BOTTOM];
        endcase
    endfunction

endpackage

// File: rtl/monster_frame_timer.sv
// Loadable per-frame down-counter; done marks a frame tick seen at zero.
module monster_frame_timer
#(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_tick,
    output logic         o_done
);
    logic [W-1:0] r_cnt;

    // Load has priority; otherwise count frames down and park at zero.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (i_tick && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_done = i_tick && (r_cnt == '0);

endmodule

// File: rtl/monster_ctrl.sv
// Monster behaviour: chase/fright/dead FSM, per-frame movement, event pulses.
module monster_ctrl
    import monster_pkg::*;
#(
    parameter logic [10:0] INIT_X          = 11'd304,
    parameter logic [10:0] INIT_Y          = 11'd224,
    parameter logic [2:0]  SPEED           = 3'd2,
    parameter logic [9:0]  FRIGHT_FRAMES   = 10'd300,
    parameter logic [9:0]  RESPAWN_FRAMES  = 10'd120,
    parameter logic [5:0]  DECISION_FRAMES = 6'd16
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        collision_wall,
    input  logic [3:0]  HitEdgeCode,
    input  logic        collision_pacman,
    input  logic        power_pulse,
    input  logic [10:0] pacmanX,
    input  logic [10:0] pacmanY,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        monster_type,
    output logic        monster_visible,
    output logic        monster_eaten,
    output logic        pacman_killed
);
    state_t      r_state, w_state_nxt;
    dir_t        r_dir, w_dir_mv, w_dir_nxt, w_seek;
    logic [10:0] r_x, r_y, w_x_nxt, w_y_nxt, w_spd;
    logic [11:0] w_dx, w_dy, w_adx, w_ady;
    logic [5:0]  r_dec, w_dec_nxt;
    logic [3:0]  r_wall;
    logic        r_pac_hit, r_type, r_vis, r_eaten, r_killed;
    logic        w_dec_hit, w_live, w_eat, w_power, w_kill, w_tdone, w_flee;
    logic        w_tload;
    logic [9:0]  w_tval;

    assign w_spd = 11'(SPEED);

    // Collision events; power resolves first, so power+hit in one cycle eats the monster.
    assign w_live  = (r_state != ST_DEAD);
    assign w_eat   = w_live && collision_pacman && (r_state == ST_FRIGHT || power_pulse);
    assign w_power = w_live && power_pulse;
    assign w_kill  = w_live && collision_pacman && (r_state == ST_CHASE) && !power_pulse
                     && (startOfFrame || !r_pac_hit);
    assign w_tload = w_eat || w_power;
    assign w_tval  = w_eat ? RESPAWN_FRAMES : FRIGHT_FRAMES;

    monster_frame_timer #(.W(10)) u_timer (
        .clk        (clk),
        .resetN     (resetN),
        .i_load     (w_tload),
        .i_load_val (w_tval),
        .i_tick     (startOfFrame),
        .o_done     (w_tdone)
    );

    // Next FSM state.
    always_comb begin
        w_state_nxt = r_state;
        if (w_eat)
            w_state_nxt = ST_DEAD;
        else if (w_power)
            w_state_nxt = ST_FRIGHT;
        else if (startOfFrame && w_tdone && r_state != ST_CHASE)
            w_state_nxt = ST_CHASE;
    end

    // Preferred heading: larger-distance axis, toward pacman or away when frightened.
    always_comb begin
        w_dx   = {1'b0, pacmanX} - {1'b0, r_x};
        w_dy   = {1'b0, pacmanY} - {1'b0, r_y};
        w_adx  = w_dx[11] ? (~w_dx + 12'd1) : w_dx;
        w_ady  = w_dy[11] ? (~w_dy + 12'd1) : w_dy;
        w_flee = (r_state == ST_FRIGHT);
        w_seek = r_dir;
        if (w_adx == 12'd0 && w_ady == 12'd0)
            w_seek = r_dir;
        else if (w_adx >= w_ady)
            w_seek = (!w_dx[11] ^ w_flee) ? DIR_RIGHT : DIR_LEFT;
        else
            w_seek = (!w_dy[11] ^ w_flee) ? DIR_DOWN : DIR_UP;
    end

    // Frame move: wall reversal beats the periodic decision; screen clamps also reverse.
    always_comb begin
        w_dec_nxt = r_dec + 6'd1;
        w_dec_hit = 1'b0;
        if (w_dec_nxt == DECISION_FRAMES) begin
            w_dec_nxt = '0;
            w_dec_hit = 1'b1;
        end
        w_dir_mv = r_dir;
        if (faces_wall(r_dir, r_wall))
            w_dir_mv = dir_flip(r_dir);
        else if (w_dec_hit)
            w_dir_mv = w_seek;
        w_dir_nxt = w_dir_mv;
        w_x_nxt   = r_x;
        w_y_nxt   = r_y;
        case (w_dir_mv)
            DIR_LEFT:
                if (r_x < w_spd) begin w_x_nxt = '0; w_dir_nxt = DIR_RIGHT; end
                else w_x_nxt = r_x - w_spd;
            DIR_RIGHT:
                if (r_x > X_MAX - w_spd) begin w_x_nxt = X_MAX; w_dir_nxt = DIR_LEFT; end
                else w_x_nxt = r_x + w_spd;
            DIR_UP:
                if (r_y < w_spd) begin w_y_nxt = '0; w_dir_nxt = DIR_DOWN; end
                else w_y_nxt = r_y - w_spd;
            default:
                if (r_y > Y_MAX - w_spd) begin w_y_nxt = Y_MAX; w_dir_nxt = DIR_UP; end
                else w_y_nxt = r_y + w_spd;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= ST_CHASE;
        else         r_state <= w_state_nxt;
    end

    // Per-frame collision latches; the startOfFrame cycle opens the new frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_wall    <= '0;
            r_pac_hit <= 1'b0;
        end else if (startOfFrame) begin
            r_wall    <= collision_wall ? HitEdgeCode : 4'd0;
            r_pac_hit <= collision_pacman;
        end else begin
            if (collision_wall)   r_wall    <= r_wall | HitEdgeCode;
            if (collision_pacman) r_pac_hit <= 1'b1;
        end
    end

    // Position, heading and decision counter; frozen while dead, respawn on expiry.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_x   <= INIT_X;
            r_y   <= INIT_Y;
            r_dir <= DIR_LEFT;
            r_dec <= '0;
        end else if (startOfFrame) begin
            if (r_state == ST_DEAD) begin
                if (w_tdone) begin
                    r_x   <= INIT_X;
                    r_y   <= INIT_Y;
                    r_dir <= DIR_LEFT;
                    r_dec <= '0;
                end
            end else begin
                r_x   <= w_x_nxt;
                r_y   <= w_y_nxt;
                r_dir <= w_dir_nxt;
                r_dec <= w_dec_nxt;
            end
        end
    end

    // Registered outputs: pulses follow their event, sprite flags change per frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_eaten  <= 1'b0;
            r_killed <= 1'b0;
            r_type   <= 1'b0;
            r_vis    <= 1'b1;
        end else begin
            r_eaten  <= w_eat;
            r_killed <= w_kill;
            if (startOfFrame) begin
                r_type <= (w_state_nxt == ST_FRIGHT);
                r_vis  <= (w_state_nxt != ST_DEAD);
            end
        end
    end

    assign topLeftX        = r_x;
    assign topLeftY        = r_y;
    assign monster_type    = r_type;
    assign monster_visible = r_vis;
    assign monster_eaten   = r_eaten;
    assign pacman_killed   = r_killed;

endmodule

// File: doc/monster_ctrl.md
MONSTER_CTRL -- requirements
Module: monster_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
  INIT_X  11'd304  respawn top-left X
  INIT_Y  11'd224  respawn top-left Y
  SPEED  3'd2  pixels moved per frame
  FRIGHT_FRAMES  10'd300  frames spent in FRIGHT
  RESPAWN_FRAMES  10'd120  frames spent in DEAD
  DECISION_FRAMES  6'd16  frames between chase/flee direction decisions
REQ-002 SHALL have ports, one per line: name  direction  width  meaning:
  clk  in  1  system clock
  resetN  in  1  reset; asynchronous, active-low
  startOfFrame  in  1  one-cycle pulse per video frame
  collision_wall  in  1  monster pixel overlaps wall this cycle
  HitEdgeCode  in  4  {Left,Top,Right,Bottom} from monster bitmap
  collision_pacman  in  1  monster pixel overlaps pacman this cycle
  power_pulse  in  1  one-cycle pulse: power pellet eaten
  pacmanX, pacmanY  in  11 each  pacman top-left
  topLeftX, topLeftY  out  11 each  monster top-left
  monster_type  out  1  0 = red (chase), 1 = green (frightened); drives bitmap select
  monster_visible  out  1  gates monster drawing
  monster_eaten  out  1  one-cycle pulse
  pacman_killed  out  1  one-cycle pulse

Function
REQ-003 SHALL implement FSM states CHASE, FRIGHT, DEAD; direction register UP/DOWN/LEFT/RIGHT.
REQ-004 Within a frame, SHALL OR-latch HitEdgeCode into wall_flags on every cycle with collision_wall=1; latch cleared on the cycle after startOfFrame.
REQ-005 Within a frame, SHALL latch pac_hit on collision_pacman=1; cleared with wall_flags.
REQ-006 On startOfFrame in CHASE/FRIGHT: if wall_flags bit facing current direction set (LEFT->bit3, UP->bit2, RIGHT->bit1, DOWN->bit0), SHALL reverse direction and move SPEED in the new direction; else move SPEED in current direction.
REQ-007 Position SHALL be clamped to X 0..607, Y 0..447 (640x480 minus 32); hitting a clamp reverses direction.
REQ-008 Decision counter SHALL count frames; on reaching DECISION_FRAMES it reloads 0 and, if no wall reversal this frame, sets direction along the axis of larger |pacman - monster| distance: toward pacman in CHASE, away in FRIGHT; tie -> X axis; zero distance -> keep direction.
REQ-009 collision_pacman=1 in CHASE SHALL emit pacman_killed once per frame (first hit cycle only); state unchanged.
REQ-010 collision_pacman=1 in FRIGHT SHALL emit monster_eaten one cycle later, enter DEAD, load RESPAWN_FRAMES.
REQ-011 power_pulse in CHASE or FRIGHT SHALL enter/restart FRIGHT with FRIGHT_FRAMES; ignored in DEAD.
REQ-012 Same-cycle power_pulse and collision_pacman SHALL resolve power first: monster eaten, no pacman_killed.
REQ-013 FRIGHT counter SHALL decrement per startOfFrame; at 0 return to CHASE.
REQ-014 DEAD: monster_visible=0, position frozen, collisions ignored; counter decrements per frame; at 0 -> CHASE, position INIT_X/INIT_Y, direction LEFT.
REQ-015 monster_type SHALL be 1 exactly in FRIGHT; outputs registered, updated the cycle after startOfFrame.

Reset
REQ-016 On resetN=0 (async, any time incl. mid-frame): state CHASE, topLeft=INIT_X/INIT_Y, direction LEFT, all counters/latches 0, monster_type=0, monster_visible=1, monster_eaten=0, pacman_killed=0.

Structure
REQ-017 monster_pkg SHALL hold state and direction enums, SCREEN_W=640, SCREEN_H=480, OBJ_SIZE=32, HitEdgeCode bit indices.
REQ-018 One sub-module monster_frame_timer (loadable down-counter, decrement on startOfFrame, done flag) SHALL be instanced for FRIGHT/DEAD timing.

Verification
REQ-019 Reset, 3 frames, no events -> topLeftX 304->302->300->298, Y 224.
REQ-020 Moving LEFT, collision_wall with HitEdgeCode=4'h8 mid-frame -> next frame direction RIGHT, X increases by 2.
REQ-021 power_pulse then collision_pacman in a later frame -> monster_type=1, monster_eaten single pulse, monster_visible=0 for 120 frames, then reappears at (304,224) with monster_type=0.
REQ-022 CHASE, collision_pacman asserted 5 cycles in one frame -> exactly one pacman_killed pulse.
REQ-023 power_pulse and collision_pacman same cycle -> monster_eaten, no pacman_killed.
REQ-024 FRIGHT with no collision, 300 frames -> back to CHASE, monster_type=0; resetN pulsed mid-frame -> all outputs at REQ-016 values immediately.
